// File: rtl/motor_pkg.sv
// motor_pkg: shared constants and types for the dual H-bridge PWM driver.
//   PWM_BITS_DEF : default width of the PWM counter and duty requests
//   PWM_PERIOD   : clocks per PWM period at the default width
//   DEAD_CNT_W   : width of the per-channel dead-time period counter
//   chan_state_e : per-channel drive state (FWD / REV / DEAD)
package motor_pkg;

  localparam int unsigned PWM_BITS_DEF = 11;
  localparam int unsigned PWM_PERIOD   = 2048;
  localparam int unsigned DEAD_CNT_W   = 3;

  typedef enum logic [1:0] {
    FWD  = 2'd0,
    REV  = 2'd1,
    DEAD = 2'd2
  } chan_state_e;

endpackage

// File: rtl/mtr_chan.sv
// mtr_chan: one H-bridge channel. Shadows duty/direction at the period
// boundary, runs the FWD/REV/DEAD direction FSM and registers both PWM legs.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : drive enable; low forces both legs off and clears duty
//   cap_i        : capture strobe, high in the last cycle of each period
//   cnt_i        : shared PWM counter
//   spd_i        : duty request (high cycles per period)
//   rev_i        : direction request, 1 = reverse
//   fwd_pwm_o    : forward leg drive
//   rev_pwm_o    : reverse leg drive
import motor_pkg::*;

module mtr_chan #(
  parameter int unsigned PWM_BITS     = PWM_BITS_DEF,
  parameter int unsigned DEAD_PERIODS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                cap_i,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic [PWM_BITS-1:0] spd_i,
  input  logic                rev_i,
  output logic                fwd_pwm_o,
  output logic                rev_pwm_o
);

  localparam logic [DEAD_CNT_W-1:0] DEAD_LAST = DEAD_CNT_W'(DEAD_PERIODS - 1);

  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic                  rev_q, rev_d;
  chan_state_e           state_q, state_d;
  logic [DEAD_CNT_W-1:0] dead_q, dead_d;
  logic                  fwd_q, fwd_d;
  logic                  revo_q, revo_d;
  logic                  on_d;

  always_comb begin
    duty_d  = duty_q;
    rev_d   = rev_q;
    state_d = state_q;
    dead_d  = dead_q;

    if (cap_i) begin
      duty_d = spd_i;
      rev_d  = rev_i;
    end
    // Enable low wins over a capture so the period after en returns stays off.
    if (!en_i) begin
      duty_d = '0;
    end

    // Direction decisions are made only at capture; rev_d is the pending target.
    if (cap_i) begin
      unique case (state_q)
        FWD: begin
          if (rev_d) begin
            state_d = DEAD;
            dead_d  = '0;
          end
        end
        REV: begin
          if (!rev_d) begin
            state_d = DEAD;
            dead_d  = '0;
          end
        end
        DEAD: begin
          if (dead_q == DEAD_LAST) begin
            state_d = rev_d ? REV : FWD;
            dead_d  = '0;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: begin
          state_d = FWD;
          dead_d  = '0;
        end
      endcase
    end

    // Registered outputs: high in the cycle after cnt == n when n < duty.
    // Both legs derive from the single current state, so they cannot overlap.
    on_d   = en_i && (cnt_i < duty_q);
    fwd_d  = on_d && (state_q == FWD);
    revo_d = on_d && (state_q == REV);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q  <= '0;
      rev_q   <= 1'b0;
      state_q <= FWD;
      dead_q  <= '0;
      fwd_q   <= 1'b0;
      revo_q  <= 1'b0;
    end else begin
      duty_q  <= duty_d;
      rev_q   <= rev_d;
      state_q <= state_d;
      dead_q  <= dead_d;
      fwd_q   <= fwd_d;
      revo_q  <= revo_d;
    end
  end

  assign fwd_pwm_o = fwd_q;
  assign rev_pwm_o = revo_q;

endmodule

// File: rtl/motor_pwm_drv.sv
// motor_pwm_drv: dual-channel motor PWM driver with dead time on reversal.
//   clk, rst                   : clock, synchronous active-high reset
//   en                         : drive enable, low forces all legs off
//   lft_spd, lft_rev           : left duty request and direction
//   rght_spd, rght_rev         : right duty request and direction
//   lft_fwd_pwm, lft_rev_pwm   : left H-bridge drive
//   rght_fwd_pwm, rght_rev_pwm : right H-bridge drive
//   period_strt                : high in the first cycle (cnt == 0) of each period
import motor_pkg::*;

module motor_pwm_drv #(
  parameter int unsigned PWM_BITS     = PWM_BITS_DEF,
  parameter int unsigned DEAD_PERIODS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PWM_BITS-1:0] lft_spd,
  input  logic                lft_rev,
  input  logic [PWM_BITS-1:0] rght_spd,
  input  logic                rght_rev,
  output logic                lft_fwd_pwm,
  output logic                lft_rev_pwm,
  output logic                rght_fwd_pwm,
  output logic                rght_rev_pwm,
  output logic                period_strt
);

  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                cap;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cap         = (cnt_q == '1);
  assign period_strt = (cnt_q == '0);

  mtr_chan #(
    .PWM_BITS    (PWM_BITS),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_lft (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .cap_i    (cap),
    .cnt_i    (cnt_q),
    .spd_i    (lft_spd),
    .rev_i    (lft_rev),
    .fwd_pwm_o(lft_fwd_pwm),
    .rev_pwm_o(lft_rev_pwm)
  );

  mtr_chan #(
    .PWM_BITS    (PWM_BITS),
    .DEAD_PERIODS(DEAD_PERIODS)
  ) u_rght (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .cap_i    (cap),
    .cnt_i    (cnt_q),
    .spd_i    (rght_spd),
    .rev_i    (rght_rev),
    .fwd_pwm_o(rght_fwd_pwm),
    .rev_pwm_o(rght_rev_pwm)
  );

endmodule

// File: tb/tb_motor_pwm_drv.sv
// Bench for motor_pwm_drv: period-level reference model (duty, direction,
// dead-time bookkeeping and enable history per period) compared against
// high-cycle counts observed over each 2048-cycle window.
module tb_motor_pwm_drv;
  import motor_pkg::*;

  localparam int PB   = 11;
  localparam int DP   = 1;
  localparam int PER  = PWM_PERIOD;
  localparam int LAST = PWM_PERIOD - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [PB-1:0] lft_spd = '0;
  logic          lft_rev = 1'b0;
  logic [PB-1:0] rght_spd = '0;
  logic          rght_rev = 1'b0;
  logic          lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_strt;

  motor_pwm_drv #(
    .PWM_BITS    (PB),
    .DEAD_PERIODS(DP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .lft_spd     (lft_spd),
    .lft_rev     (lft_rev),
    .rght_spd    (rght_spd),
    .rght_rev    (rght_rev),
    .lft_fwd_pwm (lft_fwd_pwm),
    .lft_rev_pwm (lft_rev_pwm),
    .rght_fwd_pwm(rght_fwd_pwm),
    .rght_rev_pwm(rght_rev_pwm),
    .period_strt (period_strt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state. mode: 0 = forward, 1 = reverse, 2 = dead time.
  int pos, first_low, ovl_cnt = 0, ps_bad = 0;
  int mode[2], nmode[2], duty[2], nduty[2], rem[2];
  int gf[2], gr[2], last_gf[2], last_gr[2], last_ef[2], last_er[2];
  bit period_done;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_clear();
    pos = 0;
    first_low = PER;
    period_done = 1'b0;
    for (int c = 0; c < 2; c++) begin
      mode[c] = 0; nmode[c] = 0; duty[c] = 0; nduty[c] = 0; rem[c] = 0;
      gf[c] = 0; gr[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
  endtask

  // Advance one cycle: account inputs of the current cycle, then sample the next.
  task automatic step();
    int sp;
    bit rv;
    int e;
    if (!en && first_low == PER) first_low = pos;
    if (pos == LAST) begin
      for (int c = 0; c < 2; c++) begin
        sp = (c == 0) ? int'(lft_spd) : int'(rght_spd);
        rv = (c == 0) ? lft_rev : rght_rev;
        nduty[c] = en ? sp : 0;
        if (mode[c] == 2) begin
          rem[c]--;
          nmode[c] = (rem[c] == 0) ? int'(rv) : 2;
        end else if (int'(rv) != mode[c]) begin
          nmode[c] = 2;
          rem[c] = DP;
        end else begin
          nmode[c] = mode[c];
        end
      end
    end
    @(posedge clk); #1;
    pos = (pos + 1) % PER;
    period_done = 1'b0;
    if (pos == 0) begin
      for (int c = 0; c < 2; c++) begin
        e = (mode[c] == 2) ? 0 : min2(duty[c], first_low);
        last_ef[c] = (mode[c] == 0) ? e : 0;
        last_er[c] = (mode[c] == 1) ? e : 0;
        last_gf[c] = gf[c];
        last_gr[c] = gr[c];
        gf[c] = 0; gr[c] = 0;
        mode[c] = nmode[c];
        duty[c] = nduty[c];
      end
      first_low = PER;
      period_done = 1'b1;
    end
    gf[0] += int'(lft_fwd_pwm);
    gr[0] += int'(lft_rev_pwm);
    gf[1] += int'(rght_fwd_pwm);
    gr[1] += int'(rght_rev_pwm);
    if (lft_fwd_pwm && lft_rev_pwm) ovl_cnt++;
    if (rght_fwd_pwm && rght_rev_pwm) ovl_cnt++;
    if (period_strt !== (pos == 0)) ps_bad++;
  endtask

  task automatic test_reset();
    en = 1'b0; lft_spd = '0; lft_rev = 1'b0; rght_spd = '0; rght_rev = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    checks++;
    if ({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=0000",
               {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm});
    end
    checks++;
    if (period_strt !== 1'b1) begin
      failures++;
      $display("FAIL reset_period_strt got=%b expected=1", period_strt);
    end
    step();
    checks++;
    if (period_strt !== 1'b0) begin
      failures++;
      $display("FAIL reset_period_strt_2nd got=%b expected=0", period_strt);
    end
    // Return to a period boundary for the following scenarios.
    while (pos != 0) step();
  endtask

  task automatic test_basic();
    int k = 0;
    en = 1'b1; lft_spd = 11'h400; lft_rev = 1'b0;
    for (int n = 0; n < 3 * PER; n++) begin
      step();
      if (period_done) begin
        for (int c = 0; c < 2; c++) begin
          checks++;
          if (last_gf[c] !== last_ef[c] || last_gr[c] !== last_er[c]) begin
            failures++;
            $display("FAIL basic_period ch%0d got fwd=%0d rev=%0d expected fwd=%0d rev=%0d",
                     c, last_gf[c], last_gr[c], last_ef[c], last_er[c]);
          end
        end
        if (k >= 1) begin
          checks++;
          if (last_gf[0] !== 1024 || last_gr[0] !== 0) begin
            failures++;
            $display("FAIL basic_const got fwd=%0d rev=%0d expected fwd=1024 rev=0",
                     last_gf[0], last_gr[0]);
          end
        end
        k++;
      end
    end
  endtask

  task automatic test_mid_change();
    int k = 0;
    int exp_f[2] = '{1024, 256};
    for (int n = 0; n < 2 * PER; n++) begin
      if (pos == 500) lft_spd = 11'h100;
      step();
      if (period_done) begin
        for (int c = 0; c < 2; c++) begin
          checks++;
          if (last_gf[c] !== last_ef[c] || last_gr[c] !== last_er[c]) begin
            failures++;
            $display("FAIL midchg_period ch%0d got fwd=%0d rev=%0d expected fwd=%0d rev=%0d",
                     c, last_gf[c], last_gr[c], last_ef[c], last_er[c]);
          end
        end
        checks++;
        if (last_gf[0] !== exp_f[k]) begin
          failures++;
          $display("FAIL midchg_const k=%0d got=%0d expected=%0d", k, last_gf[0], exp_f[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_reversal();
    int k = 0;
    int exp_f[5] = '{256, 512, 512, 0, 0};
    int exp_r[5] = '{0, 0, 0, 0, 768};
    lft_spd = 11'h200; lft_rev = 1'b0;
    for (int n = 0; n < 5 * PER; n++) begin
      if (n == 2 * PER) begin lft_rev = 1'b1; lft_spd = 11'h300; end
      step();
      if (period_done) begin
        for (int c = 0; c < 2; c++) begin
          checks++;
          if (last_gf[c] !== last_ef[c] || last_gr[c] !== last_er[c]) begin
            failures++;
            $display("FAIL reversal_period ch%0d got fwd=%0d rev=%0d expected fwd=%0d rev=%0d",
                     c, last_gf[c], last_gr[c], last_ef[c], last_er[c]);
          end
        end
        checks++;
        if (last_gf[0] !== exp_f[k] || last_gr[0] !== exp_r[k]) begin
          failures++;
          $display("FAIL reversal_const k=%0d got fwd=%0d rev=%0d expected fwd=%0d rev=%0d",
                   k, last_gf[0], last_gr[0], exp_f[k], exp_r[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_full_zero_en();
    int k = 0;
    int exp_f[6] = '{0, 2047, 2047, 0, 1000, 2047};
    rght_spd = 11'h7FF; rght_rev = 1'b0;
    for (int n = 0; n < 6 * PER; n++) begin
      if (n == 2 * PER) rght_spd = 11'h000;
      if (n == 3 * PER) rght_spd = 11'h7FF;
      if (n == 4 * PER + 1000) begin
        checks++;
        if (rght_fwd_pwm !== 1'b1) begin
          failures++;
          $display("FAIL en_before_drop got=%b expected=1", rght_fwd_pwm);
        end
        en = 1'b0;
      end
      if (n == 4 * PER + 1500) en = 1'b1;
      step();
      if (n == 4 * PER + 1000) begin
        checks++;
        if ({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm} !== 4'b0000) begin
          failures++;
          $display("FAIL en_drop_next_cycle got=%b expected=0000",
                   {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm});
        end
      end
      if (period_done) begin
        for (int c = 0; c < 2; c++) begin
          checks++;
          if (last_gf[c] !== last_ef[c] || last_gr[c] !== last_er[c]) begin
            failures++;
            $display("FAIL fullzero_period ch%0d got fwd=%0d rev=%0d expected fwd=%0d rev=%0d",
                     c, last_gf[c], last_gr[c], last_ef[c], last_er[c]);
          end
        end
        checks++;
        if (last_gf[1] !== exp_f[k] || last_gr[1] !== 0) begin
          failures++;
          $display("FAIL fullzero_const k=%0d got fwd=%0d rev=%0d expected fwd=%0d rev=0",
                   k, last_gf[1], last_gr[1], exp_f[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_dead_reset();
    int k = 0;
    int exp_f[2] = '{0, 768};
    // Left is in reverse at 0x300; request forward so the next period is dead.
    lft_rev = 1'b0;
    for (int n = 0; n < PER + 600; n++) step();
    checks++;
    if (lft_fwd_pwm !== 1'b0 || lft_rev_pwm !== 1'b0 || mode[0] !== 2) begin
      failures++;
      $display("FAIL dead_before_rst got fwd=%b rev=%b mode=%0d expected fwd=0 rev=0 mode=2",
               lft_fwd_pwm, lft_rev_pwm, mode[0]);
    end
    do_reset();
    checks++;
    if ({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_strt} !== 5'b00001) begin
      failures++;
      $display("FAIL dead_rst_state got=%b expected=00001",
               {lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_strt});
    end
    for (int n = 0; n < 2 * PER; n++) begin
      step();
      if (period_done) begin
        for (int c = 0; c < 2; c++) begin
          checks++;
          if (last_gf[c] !== last_ef[c] || last_gr[c] !== last_er[c]) begin
            failures++;
            $display("FAIL deadrst_period ch%0d got fwd=%0d rev=%0d expected fwd=%0d rev=%0d",
                     c, last_gf[c], last_gr[c], last_ef[c], last_er[c]);
          end
        end
        checks++;
        if (last_gf[0] !== exp_f[k] || last_gr[0] !== 0) begin
          failures++;
          $display("FAIL deadrst_const k=%0d got fwd=%0d rev=%0d expected fwd=%0d rev=0",
                   k, last_gf[0], last_gr[0], exp_f[k]);
        end
        k++;
      end
    end
  endtask

  function automatic logic [PB-1:0] pick_spd();
    int r = $urandom_range(0, 5);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return PB'($urandom);
  endfunction

  task automatic test_random();
    for (int n = 0; n < 12 * PER; n++) begin
      if ($urandom_range(0, 700) == 0) lft_spd = pick_spd();
      if ($urandom_range(0, 700) == 0) rght_spd = pick_spd();
      if ($urandom_range(0, 1500) == 0) lft_rev = ~lft_rev;
      if ($urandom_range(0, 1500) == 0) rght_rev = ~rght_rev;
      if (en && $urandom_range(0, 4000) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 300) == 0) en = 1'b1;
      step();
      if (period_done) begin
        for (int c = 0; c < 2; c++) begin
          checks++;
          if (last_gf[c] !== last_ef[c] || last_gr[c] !== last_er[c]) begin
            failures++;
            $display("FAIL random_period ch%0d got fwd=%0d rev=%0d expected fwd=%0d rev=%0d",
                     c, last_gf[c], last_gr[c], last_ef[c], last_er[c]);
          end
        end
      end
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (ovl_cnt !== 0) begin
      failures++;
      $display("FAIL leg_overlap got=%0d cycles expected=0", ovl_cnt);
    end
    checks++;
    if (ps_bad !== 0) begin
      failures++;
      $display("FAIL period_strt_track got=%0d bad cycles expected=0", ps_bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_change();
    test_reversal();
    test_full_zero_en();
    test_dead_reset();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
